fetch_queue: RTL and testbench

- Small instruction prefetch FIFO between the fetch stage (PC plus instruction ROM output) and the IF/ID pipeline register.
- Decouples fetch from decode stalls: fetch keeps filling the queue while decode is held.
- Feeds IF/ID from the queue head.
- A taken branch or jump from Execute flushes all queued entries in one cycle.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo_ctrl.sv | 51 +++++
 rtl/fetch_queue.sv | 57 +++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types for the fetch side of the core.
// Holds the IF entry bundle and the bubble instruction value.
package fetch_queue_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_queue_fifo_ctrl.sv
// Pointer/occupancy control for the fetch queue.
// Ports: clk, rst, flush, push_valid, pop_en -> wr_en, rd_ptr, wr_ptr, cnt, full, empty.
module fetch_queue_fifo_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic             pop_en,
  output logic             wr_en,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic push_fire;
  logic pop_fire;

  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign push_fire = push_valid & ~full;
  assign pop_fire  = pop_en & ~empty;
  // Wrong-path fetch during a flush is never stored.
  assign wr_en     = push_fire & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)
        cnt <= cnt + 1'b1;
      else if (pop_fire && !push_fire)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and the IF/ID register.
// Ports: push side (push_valid/ready, PC_in, Instr_in), pop side (pop_en/valid, PC_out, Instr_out), flush, count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           push_valid,
  output logic           push_ready,
  input  logic [63:0]    PC_in,
  input  logic [31:0]    Instr_in,
  input  logic           pop_en,
  output logic           pop_valid,
  output logic [63:0]    PC_out,
  output logic [31:0]    Instr_out,
  output logic [PTR_W:0] count
);

  if_entry_t        mem [DEPTH];
  if_entry_t        head;
  logic             wr_en;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;

  fetch_queue_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .pop_en     (pop_en),
    .wr_en      (wr_en),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .cnt        (count),
    .full       (full),
    .empty      (empty)
  );

  // Storage needs no reset; only occupied slots are ever shown.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pc: PC_in, instr: Instr_in};
  end

  assign head       = mem[rd_ptr];
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  // Empty head reads as a zero bubble for IF/ID.
  assign PC_out     = empty ? 64'h0 : head.pc;
  assign Instr_out  = empty ? NOP_INSTR : head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Drives push/pop/flush/reset vectors and checks head, flags and occupancy.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           push_valid;
  logic           push_ready;
  logic [63:0]    PC_in;
  logic [31:0]    Instr_in;
  logic           pop_en;
  logic           pop_valid;
  logic [63:0]    PC_out;
  logic [31:0]    Instr_out;
  logic [PTR_W:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .PC_in      (PC_in),
    .Instr_in   (Instr_in),
    .pop_en     (pop_en),
    .pop_valid  (pop_valid),
    .PC_out     (PC_out),
    .Instr_out  (Instr_out),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("inv_cnt_le_depth",
          64'(dut.u_ctrl.cnt <= 3'(DEPTH)), 64'd1);
      chk("inv_pop_valid",
          64'(pop_valid), 64'(dut.u_ctrl.cnt != 0));
      chk("inv_push_ready",
          64'(push_ready), 64'(dut.u_ctrl.cnt != 3'(DEPTH)));
      chk("inv_ptr_diff",
          64'(2'(dut.u_ctrl.wr_ptr - dut.u_ctrl.rd_ptr)),
          64'(dut.u_ctrl.cnt[PTR_W-1:0]));
    end
  end

  logic [31:0] tab [4];
  logic [63:0] pc;

  initial begin
    tab[0] = 32'h00a00093;
    tab[1] = 32'h0000b103;
    tab[2] = 32'h001101b3;
    tab[3] = 32'h00000463;
    rst = 1'b0; flush = 1'b0; push_valid = 1'b0;
    pop_en = 1'b0; PC_in = '0; Instr_in = '0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pc_out", PC_out, 64'd0);
    chk("rst_instr_out", 64'(Instr_out), 64'd0);
    #10 rst = 1'b1;
    step();

    // Fill in order, decode stalled
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      PC_in = 64'(4 * i);
      Instr_in = tab[i];
      step();
      chk("fill_head_pc", PC_out, 64'd0);
      chk("fill_head_instr", 64'(Instr_out), 64'(tab[0]));
      chk("fill_count", 64'(count), 64'(i + 1));
    end
    push_valid = 1'b0;
    chk("full_push_ready", 64'(push_ready), 64'd0);
    pop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", PC_out, 64'(4 * i));
      chk("drain_instr", 64'(Instr_out), 64'(tab[i]));
      step();
    end
    pop_en = 1'b0;
    chk("drain_pop_valid", 64'(pop_valid), 64'd0);
    chk("drain_instr_zero", 64'(Instr_out), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      PC_in = 64'(16 + 4 * i);
      Instr_in = ins(PC_in);
      step();
    end
    chk("full2_count", 64'(count), 64'd4);
    PC_in = 64'd32;
    Instr_in = ins(64'd32);
    pop_en = 1'b1;
    step();
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_head", PC_out, 64'd20);
    pop_en = 1'b0;
    step();
    chk("fullpop_retry_count", 64'(count), 64'd4);
    push_valid = 1'b0;
    pop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 64'(20 + 4 * i);
      chk("fullpop_order_pc", PC_out, pc);
      chk("fullpop_order_instr", 64'(Instr_out), 64'(ins(pc)));
      step();
    end
    pop_en = 1'b0;
    chk("fullpop_empty", 64'(pop_valid), 64'd0);

    // Steady stream, pointers wrap
    push_valid = 1'b1;
    PC_in = 64'd200;
    Instr_in = ins(64'd200);
    step();
    pop_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      PC_in = 64'(204 + 4 * k);
      Instr_in = ins(PC_in);
      step();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_pc", PC_out, 64'(204 + 4 * k));
      chk("stream_instr", 64'(Instr_out), 64'(ins(64'(204 + 4 * k))));
    end
    push_valid = 1'b0;
    step();
    pop_en = 1'b0;
    chk("stream_drained", 64'(count), 64'd0);

    // Flush with simultaneous push and pop
    push_valid = 1'b1;
    PC_in = 64'd300; Instr_in = ins(64'd300); step();
    PC_in = 64'd304; Instr_in = ins(64'd304); step();
    chk("preflush_count", 64'(count), 64'd2);
    flush = 1'b1;
    pop_en = 1'b1;
    PC_in = 64'd100; Instr_in = ins(64'd100);
    step();
    flush = 1'b0;
    pop_en = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_pop_valid", 64'(pop_valid), 64'd0);
    chk("flush_push_ready", 64'(push_ready), 64'd1);
    chk("flush_pc_zero", PC_out, 64'd0);
    step();
    push_valid = 1'b0;
    chk("redirect_pc", PC_out, 64'd100);
    chk("redirect_instr", 64'(Instr_out), 64'(ins(64'd100)));
    chk("redirect_count", 64'(count), 64'd1);

    // Pop on empty is a no-op
    pop_en = 1'b1;
    step();
    step();
    chk("empty_pop_count", 64'(count), 64'd0);
    chk("empty_pop_valid", 64'(pop_valid), 64'd0);
    pop_en = 1'b0;

    // Decode stall while fetching
    push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PC_in = 64'(400 + 4 * i);
      Instr_in = ins(PC_in);
      step();
      chk("stall_head_pc", PC_out, 64'd400);
      chk("stall_head_instr", 64'(Instr_out), 64'(ins(64'd400)));
      chk("stall_count", 64'(count), 64'(i + 1));
    end
    push_valid = 1'b0;

    // Asynchronous reset with 3 queued
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pop_valid", 64'(pop_valid), 64'd0);
    chk("arst_push_ready", 64'(push_ready), 64'd1);
    chk("arst_instr_out", 64'(Instr_out), 64'd0);
    chk("arst_pc_out", PC_out, 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
